// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole mole scheduler.
package mole_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GAP     = 2'd1,
    SHOW    = 2'd2,
    RESOLVE = 2'd3
  } state_e;

  localparam logic [1:0] LVL_EASY = 2'd0;
  localparam logic [1:0] LVL_MED  = 2'd1;
  localparam logic [1:0] LVL_HARD = 2'd2;

  // Polynomial x^16+x^14+x^13+x^11 in right-shift form: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Fibonacci LFSR; shifts right each enabled cycle, reset loads SEED.
module mole_lfsr
  import mole_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else if (en_i) begin
      lfsr_q <= {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/mole_scheduler.sv
// Mole scheduler: picks a non-repeating mole, times its window, resolves hammers.
// Optional MOLE_SPEEDUP_EN shortens the window by the current streak.
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int          NUM_MOLES      = 5,
  parameter int          EASY_TICKS     = 300_000_000,
  parameter int          MED_TICKS      = 200_000_000,
  parameter int          HARD_TICKS     = 100_000_000,
  parameter int          GAP_TICKS      = 25_000_000,
  parameter int          SPEEDUP_TICKS  = 10_000_000,
  parameter int          MIN_SHOW_TICKS = 50_000_000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           level,
  input  logic [NUM_MOLES-1:0] hit_vec,
  output logic [NUM_MOLES-1:0] mole_led,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic                 timeout_pulse,
  output logic [3:0]           streak,
  output logic                 busy
);

  localparam int MAX_TICKS = (EASY_TICKS > GAP_TICKS) ? EASY_TICKS : GAP_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS);
  localparam int WIN_W     = CNT_W + 5;
  localparam int IDX_W     = $clog2(NUM_MOLES + 1);
  localparam logic [CNT_W-1:0] GAP_M1 = CNT_W'(GAP_TICKS - 1);
`ifdef MOLE_SPEEDUP_EN
  localparam bit SPEEDUP_ON = 1'b1;
`else
  localparam bit SPEEDUP_ON = 1'b0;
`endif

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       win_m1_q;
  logic [IDX_W-1:0]       prev_q;
  logic [NUM_MOLES-1:0]   mole_led_q;
  logic                   hit_q, miss_q, timeout_q, busy_q;
  logic [3:0]             streak_q;
  logic [15:0]            lfsr_w;
  logic [7:0]             mod_w;
  logic [IDX_W-1:0]       idx_raw, idx_pick;
  logic                   unused_lfsr_hi;

  // Window minus one, so the stored value always fits the counter width.
  function automatic logic [CNT_W-1:0] win_m1(input logic [1:0] lvl, input logic [3:0] stk);
    logic [WIN_W-1:0] base, cut, win;
    case (lvl)
      LVL_EASY: base = WIN_W'(EASY_TICKS);
      LVL_MED:  base = WIN_W'(MED_TICKS);
      default:  base = WIN_W'(HARD_TICKS);
    endcase
    cut = WIN_W'(stk) * WIN_W'(SPEEDUP_TICKS);
    win = base;
    if (SPEEDUP_ON)
      win = (base > cut + WIN_W'(MIN_SHOW_TICKS)) ? base - cut : WIN_W'(MIN_SHOW_TICKS);
    return CNT_W'(win - WIN_W'(1));
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (enable),
    .lfsr_o (lfsr_w)
  );

  assign unused_lfsr_hi = ^lfsr_w[15:8];

  always_comb begin
    mod_w    = lfsr_w[7:0] % 8'(NUM_MOLES);
    idx_raw  = IDX_W'(mod_w);
    idx_pick = idx_raw;
    if (idx_raw == prev_q)
      idx_pick = (idx_raw == IDX_W'(NUM_MOLES - 1)) ? '0 : idx_raw + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      win_m1_q   <= '0;
      prev_q     <= IDX_W'(NUM_MOLES);
      mole_led_q <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      timeout_q  <= 1'b0;
      streak_q   <= 4'd0;
      busy_q     <= 1'b0;
    end else begin
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= enable;
      if (!enable) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        mole_led_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            streak_q <= 4'd0;
            cnt_q    <= '0;
            state_q  <= GAP;
          end
          GAP: begin
            if (cnt_q == GAP_M1) begin
              cnt_q      <= '0;
              state_q    <= SHOW;
              prev_q     <= idx_pick;
              mole_led_q <= NUM_MOLES'(1) << idx_pick;
              win_m1_q   <= win_m1(level, streak_q);
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          SHOW: begin
            // A hammer in the last window cycle beats the expiry.
            if (hit_vec != '0) begin
              state_q    <= RESOLVE;
              cnt_q      <= '0;
              mole_led_q <= '0;
              if ((hit_vec & mole_led_q) != '0) hit_q  <= 1'b1;
              else                              miss_q <= 1'b1;
            end else if (cnt_q == win_m1_q) begin
              state_q    <= RESOLVE;
              cnt_q      <= '0;
              mole_led_q <= '0;
              timeout_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          RESOLVE: begin
            streak_q <= hit_q ? sat_inc(streak_q) : 4'd0;
            state_q  <= GAP;
          end
        endcase
      end
    end
  end

  assign mole_led      = mole_led_q;
  assign hit_pulse     = hit_q;
  assign miss_pulse    = miss_q;
  assign timeout_pulse = timeout_q;
  assign streak        = streak_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed, table-driven bench for mole_scheduler (small tick counts).
module tb_mole_scheduler;

  localparam int NM = 5, EASY = 30, MED = 20, HARD = 10, GAP = 5, SPD = 4, MINW = 12;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef MOLE_SPEEDUP_EN
  localparam int W1 = 16, W2 = 12, WT = 12;
`else
  localparam int W1 = 20, W2 = 20, WT = 20;
`endif
  localparam logic [2:0] EV_HIT = 3'b100, EV_MISS = 3'b010, EV_TO = 3'b001;

  logic          clk, rst_n, enable;
  logic [1:0]    level;
  logic [NM-1:0] hit_vec, mole_led;
  logic          hit_pulse, miss_pulse, timeout_pulse, busy;
  logic [3:0]    streak;

  typedef struct {
    logic [1:0] lvl;
    int         kind;   // 0 none, 1 hit, 2 miss, 3 hit plus extra bit
    int         at;     // SHOW cycle of the hammer
    int         lit;    // expected lit cycles
    logic [2:0] ev;     // {hit, miss, timeout}
    int         stk;    // streak after resolve
  } vec_t;

  vec_t tbl [0:29];

  int n_chk = 0, n_fail = 0, cur = -1, gap_base = 0, m_prev = NM;
  logic [15:0]   m_lfsr;
  logic [NM-1:0] last_led, last_mole;

  mole_scheduler #(
    .NUM_MOLES(NM), .EASY_TICKS(EASY), .MED_TICKS(MED), .HARD_TICKS(HARD),
    .GAP_TICKS(GAP), .SPEEDUP_TICKS(SPD), .MIN_SHOW_TICKS(MINW), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .level(level), .hit_vec(hit_vec),
    .mole_led(mole_led), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .timeout_pulse(timeout_pulse), .streak(streak), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1000000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got %0d, expected %0d", name, cur, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic int pick(input logic [15:0] l, input int prev);
    int r;
    r = int'(l[7:0]) % NM;
    if (r == prev) r = (r + 1) % NM;
    return r;
  endfunction

  function automatic logic [NM-1:0] hammer(input int kind, input logic [NM-1:0] led);
    logic [NM-1:0] rot;
    rot = {led[NM-2:0], led[NM-1]};
    case (kind)
      1:       return led;
      2:       return rot;
      3:       return led | rot;
      default: return '0;
    endcase
  endfunction

  // One clock; checks the index of every newly lit mole against the LFSR model.
  task automatic tick();
    logic [15:0] pre;
    int e;
    pre = m_lfsr;
    @(posedge clk);
    if (enable && rst_n) m_lfsr = lfsr_step(m_lfsr);
    @(negedge clk);
    if (mole_led != '0 && last_led == '0) begin
      e = pick(pre, m_prev);
      check("mole_idx", int'(mole_led), 1 << e);
      check("no_repeat", int'(mole_led == last_mole), 0);
      m_prev    = e;
      last_mole = mole_led;
    end
    last_led = mole_led;
  endtask

  task automatic wait_lit();
    int n;
    n = gap_base;
    while (mole_led == '0 && n < 100) begin
      tick();
      n++;
    end
    check("gap_len", n, GAP + 1);
  endtask

  task automatic run_vec(input vec_t v);
    int lit;
    level = v.lvl;
    wait_lit();
    lit = 0;
    while (mole_led != '0 && lit < 100) begin
      lit++;
      if (v.kind != 0 && lit - 1 == v.at) hit_vec = hammer(v.kind, mole_led);
      tick();
      hit_vec = '0;
    end
    check("lit_len", lit, v.lit);
    check("event", int'({hit_pulse, miss_pulse, timeout_pulse}), int'(v.ev));
    tick();
    check("streak", int'(streak), v.stk);
    gap_base = 1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; level = 2'd0; hit_vec = '0;
    m_lfsr = SEED; last_led = '0; last_mole = '0;

    tbl[0]  = '{2'd0, 0, 0,      EASY, EV_TO,   0};
    tbl[1]  = '{2'd2, 1, 3,      4,    EV_HIT,  1};
    tbl[2]  = '{2'd2, 3, 0,      1,    EV_HIT,  2};
    tbl[3]  = '{2'd1, 1, 5,      6,    EV_HIT,  3};
    tbl[4]  = '{2'd1, 2, 2,      3,    EV_MISS, 0};
    tbl[5]  = '{2'd3, 0, 0,      HARD, EV_TO,   0};
    tbl[6]  = '{2'd2, 1, HARD-1, HARD, EV_HIT,  1};
    tbl[7]  = '{2'd1, 2, 0,      1,    EV_MISS, 0};
    tbl[8]  = '{2'd1, 1, MED-1,  MED,  EV_HIT,  1};
    tbl[9]  = '{2'd1, 1, W1-1,   W1,   EV_HIT,  2};
    tbl[10] = '{2'd1, 1, W2-1,   W2,   EV_HIT,  3};
    tbl[11] = '{2'd1, 1, W2-1,   W2,   EV_HIT,  4};
    tbl[12] = '{2'd1, 1, W2-1,   W2,   EV_HIT,  5};
    tbl[13] = '{2'd1, 0, 0,      WT,   EV_TO,   0};
    for (int k = 0; k < 16; k++)
      tbl[14+k] = '{2'd2, 1, 0, 1, EV_HIT, (k + 1 > 15) ? 15 : k + 1};

    repeat (2) @(negedge clk);
    check("rst_led", int'(mole_led), 0);
    check("rst_pulses", int'({hit_pulse, miss_pulse, timeout_pulse}), 0);
    check("rst_streak", int'(streak), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_lfsr", int'(dut.lfsr_w), int'(SEED));
    rst_n = 1'b1;
    tick(); tick();
    check("idle_busy", int'(busy), 0);

    enable = 1'b1;
    gap_base = 0;
    for (int i = 0; i < 30; i++) begin
      cur = i;
      run_vec(tbl[i]);
    end

    // Reset asserted in the middle of GAP.
    cur = 100;
    tick();
    check("pre_rst_busy", int'(busy), 1);
    check("pre_rst_streak", int'(streak), 15);
    rst_n = 1'b0;
    #1;
    check("arst_led", int'(mole_led), 0);
    check("arst_pulses", int'({hit_pulse, miss_pulse, timeout_pulse}), 0);
    check("arst_streak", int'(streak), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_lfsr", int'(dut.lfsr_w), int'(SEED));
    m_lfsr = SEED; m_prev = NM; last_led = '0; last_mole = '0;
    tick();
    rst_n = 1'b1;
    tick();
    hit_vec = '1;
    tick();
    hit_vec = '0;
    check("gap_hammer", int'({hit_pulse, miss_pulse, timeout_pulse}), 0);
    gap_base = 2;
    run_vec('{2'd2, 1, 2, 3, EV_HIT, 1});

    // Enable dropped mid-SHOW together with a hammer.
    cur = 101;
    level = 2'd2;
    wait_lit();
    tick(); tick();
    check("show_on", int'(mole_led != '0), 1);
    enable = 1'b0;
    hit_vec = mole_led;
    tick();
    hit_vec = '0;
    check("dis_led", int'(mole_led), 0);
    check("dis_pulses", int'({hit_pulse, miss_pulse, timeout_pulse}), 0);
    check("dis_busy", int'(busy), 0);
    repeat (3) tick();
    check("dis_streak_hold", int'(streak), 1);
    enable = 1'b1;
    tick();
    check("en_busy", int'(busy), 1);
    check("en_streak_clr", int'(streak), 0);
    gap_base = 1;
    wait_lit();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mole_scheduler.md
# mole_scheduler

Sequences mole appearances for the whack-a-mole game. It replaces the free-running mole/random generator beside the game-control FSM. It picks a pseudo-random, non-repeating LED, holds it lit for a difficulty-dependent window, resolves hammer hits against the lit mole, and reports hit, miss and timeout events plus a consecutive-hit streak to the score counter and the FSM.

## Interface
- NUM_MOLES, 5, number of mole LEDs/switches (2..8)
- EASY_TICKS, 300_000_000, show window at level 0
- MED_TICKS, 200_000_000, show window at level 1
- HARD_TICKS, 100_000_000, show window at level 2 (level 3 behaves as level 2)
- GAP_TICKS, 25_000_000, dark time between moles
- SPEEDUP_TICKS, 10_000_000, window reduction per streak step (speed-up build only)
- MIN_SHOW_TICKS, 50_000_000, floor for the reduced window
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  high while the game runs
- level  in  2  difficulty, sampled on entry to SHOW
- hit_vec  in  NUM_MOLES  one-cycle pulse, switch vector sampled at hammer press
- mole_led  out  NUM_MOLES  one-hot lit mole, or zero
- hit_pulse  out  1  one cycle, correct mole hit
- miss_pulse  out  1  one cycle, hammer with lit mole not selected
- timeout_pulse  out  1  one cycle, window expired unhit
- streak  out  4  consecutive hits, saturating at 15
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, GAP, SHOW, RESOLVE.
- IDLE: mole_led=0 and counter cleared. When enable=1, go to GAP.
- GAP: count GAP_TICKS cycles, then go to SHOW. Entering SHOW latches the chosen mole index and the window length.
- Mole choice: LFSR is 16-bit Fibonacci, taps 16,14,13,11, and advances every cycle while enable=1. idx = lfsr[7:0] mod NUM_MOLES. If idx equals the previous index, use (idx+1) mod NUM_MOLES. The previous index resets to NUM_MOLES, meaning none.
- SHOW: mole_led = 1<<idx. The counter counts up to window-1.
  - hit_vec[idx]=1: hit. Other hit_vec bits set in the same pulse are ignored.
  - hit_vec≠0 with hit_vec[idx]=0: miss.
  - Counter reaching window-1 with no hammer: timeout.
  - Hammer and expiry in the same cycle: the hammer result wins.
  - hit_vec outside SHOW is ignored and produces no pulse.
- RESOLVE (one cycle): mole_led=0 and exactly one of hit_pulse/miss_pulse/timeout_pulse is high. streak increments on hit and clears on miss or timeout. Next state is GAP.
- enable falling in any state: next cycle IDLE, mole_led=0, no pulse. streak holds its value until the next enable rise, when it clears.
- Reset: state IDLE, all outputs 0, LFSR=LFSR_SEED, previous index = none.
- Counter width is $clog2 of the largest of EASY_TICKS and GAP_TICKS. Window arithmetic runs at that width with no overflow.

## Timing
- Outputs are registered.
- enable rise to first mole lit: GAP_TICKS+1 cycles.
- Mole stays lit for exactly window cycles on timeout.
- Hammer pulse in cycle N: mole_led=0 and the event pulse in cycle N+1, streak updated in N+2.
- Next mole lit GAP_TICKS+1 cycles after RESOLVE.

## Configuration
- MOLE_SPEEDUP_EN defined: window = max(base(level) − streak×SPEEDUP_TICKS, MIN_SHOW_TICKS), computed on SHOW entry.
- MOLE_SPEEDUP_EN undefined: window = base(level). SPEEDUP_TICKS and MIN_SHOW_TICKS are unused, and the streak logic remains.

## Structure
- Shared package `mole_pkg` holds:
  - the state enum (IDLE/GAP/SHOW/RESOLVE)
  - level encodings (EASY=0, MED=1, HARD=2)
  - the LFSR tap constant
- Sub-module `mole_lfsr`: 16-bit LFSR with enable and seed. It outputs the raw state; the scheduler does the modulo and no-repeat logic.

## Test plan
Bench parameters: EASY=30, MED=20, HARD=10, GAP=5, SPEEDUP=4, MIN=12.
- Reset, enable=1, level=0, no hammer -> mole lit at cycle 6 for 30 cycles. timeout_pulse for 1 cycle, streak=0, next mole lit 6 cycles later, and its index differs from the previous one.
- level=2, hit_vec=1<<idx at cycle 3 of SHOW -> hit_pulse next cycle, mole_led=0, streak=1.
- hit_vec with idx bit clear (e.g. another bit) -> miss_pulse, streak clears from 3 to 0.
- hit_vec[idx] in the final SHOW cycle -> hit_pulse only, timeout_pulse never asserted.
- MOLE_SPEEDUP_EN, level=1, five consecutive hits -> windows 20,16,12,12,12.
- enable dropped mid-SHOW, and rst_n asserted mid-GAP -> LED off next cycle, no pulse. After reset all outputs are 0 and the LFSR equals the seed.
